// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared types and helpers for the multi-channel quadrature encoder interface
package qei_pkg;

    typedef enum logic [1:0] {
        X1 = 2'd0,
        X2 = 2'd1,
        X4 = 2'd2
    } decode_mode_e;

    typedef struct packed {
        logic signed [1:0] step;
        logic              illegal;
    } qei_step_t;

    // {A,B} forward order is 00 -> 10 -> 11 -> 01 -> 00
    function automatic qei_step_t qei_decode(input logic [1:0] prev, input logic [1:0] cur);
        qei_step_t r;
        r.step    = 2'sd0;
        r.illegal = 1'b0;
        case ({prev, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: r.step = 2'sd1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: r.step = -2'sd1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: r.illegal = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [1:0]  d,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
        logic signed [63:0] sum;
        sum = a + $signed({{62{d[1]}}, d});
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/qei_channel.sv
// rtl/qei_channel.sv - one encoder channel: sync, deglitch, decode, position, error and velocity accumulator
module qei_channel
    import qei_pkg::*;
#(
    parameter int     POS_W    = 32,
    parameter int     VEL_W    = 24,
    parameter int     CNT_MODE = 2,
    parameter int     FILT_LEN = 3,
    parameter longint POS_MIN  = -(longint'(1) <<< (POS_W - 1)),
    parameter longint POS_MAX  = (longint'(1) <<< (POS_W - 1)) - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    pos_clr,
    input  logic                    pos_load,
    input  logic [POS_W-1:0]        pos_load_val,
    input  logic                    err_clr,
    input  logic                    win_end,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    limit,
    output logic                    err,
    output logic signed [VEL_W-1:0] vel
);

    localparam decode_mode_e MODE      = decode_mode_e'(CNT_MODE[1:0]);
    localparam logic [3:0]   FILT_LAST = 4'(FILT_LEN - 1);
    localparam longint       VEL_MIN   = -(longint'(1) <<< (VEL_W - 1));
    localparam longint       VEL_MAX   = (longint'(1) <<< (VEL_W - 1)) - 1;

    logic [1:0]              sync1_q, sync2_q;
    logic [1:0]              filt_q, filt_d;
    logic [1:0][3:0]         cnt_q, cnt_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    limit_q, limit_d;
    logic                    err_q, err_d;
    logic signed [VEL_W-1:0] acc_q, acc_d, acc_sum;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic signed [63:0]      pos_ext_q, pos_ext_d, acc_ext_q;
    qei_step_t               dec;
    logic signed [1:0]       cstep;

    assign pos_ext_q = $signed({{(64 - POS_W){pos_q[POS_W-1]}}, pos_q});
    assign pos_ext_d = $signed({{(64 - POS_W){pos_d[POS_W-1]}}, pos_d});
    assign acc_ext_q = $signed({{(64 - VEL_W){acc_q[VEL_W-1]}}, acc_q});

    // A level is accepted on the FILT_LEN-th consecutive differing sample
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == FILT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = 4'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    always_comb begin
        dec   = qei_decode(filt_q, filt_d);
        cstep = 2'sd0;
        case (MODE)
            X4: cstep = dec.step;
            X2: begin
                if (filt_q[1] != filt_d[1]) begin
                    cstep = dec.step;
                end
            end
            default: begin
                if (filt_q == 2'b00 && filt_d == 2'b10) begin
                    cstep = 2'sd1;
                end else if (filt_q == 2'b10 && filt_d == 2'b00) begin
                    cstep = -2'sd1;
                end
            end
        endcase
    end

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        err_d   = err_q;
        acc_sum = VEL_W'(sat_add(acc_ext_q, cstep, VEL_MIN, VEL_MAX));
        acc_d   = acc_sum;
        vel_d   = vel_q;
        if (pos_clr) begin
            pos_d = '0;
        end else if (pos_load) begin
            pos_d = $signed(pos_load_val);
        end else if (cstep != 2'sd0) begin
            pos_d = POS_W'(sat_add(pos_ext_q, cstep, POS_MIN, POS_MAX));
        end
        if (dec.step != 2'sd0) begin
            dir_d = (dec.step == 2'sd1);
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (dec.illegal) begin
            err_d = 1'b1;
        end
        if (win_end) begin
            vel_d = acc_sum;
            acc_d = '0;
        end
    end

    assign limit_d = (pos_ext_d == POS_MIN) || (pos_ext_d == POS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            limit_q <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            vel_q   <= '0;
        end else begin
            sync1_q <= {a_in, b_in};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
        end
    end

    assign position = pos_q;
    assign dir      = dir_q;
    assign limit    = limit_q;
    assign err      = err_q;
    assign vel      = vel_q;

endmodule

// File: rtl/qei_multi.sv
// rtl/qei_multi.sv - multi-channel quadrature encoder interface with shared velocity window
module qei_multi
    import qei_pkg::*;
#(
    parameter int     NUM_CH        = 2,
    parameter int     POS_W         = 32,
    parameter int     VEL_W         = 24,
    parameter int     CNT_MODE      = 2,
    parameter int     FILT_LEN      = 3,
    parameter int     SAMPLE_CYCLES = 10_000_000,
    parameter longint POS_MIN       = -(longint'(1) <<< (POS_W - 1)),
    parameter longint POS_MAX       = (longint'(1) <<< (POS_W - 1)) - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_a,
    input  logic [NUM_CH-1:0]         ch_b,
    input  logic [NUM_CH-1:0]         pos_clr,
    input  logic [NUM_CH-1:0]         pos_load,
    input  logic [POS_W-1:0]          pos_load_val,
    input  logic [NUM_CH-1:0]         err_clr,
    output logic [NUM_CH*POS_W-1:0]   position,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         limit,
    output logic [NUM_CH-1:0]         err,
    output logic [NUM_CH*VEL_W-1:0]   vel,
    output logic                      vel_valid
);

    localparam int TMR_W = $clog2(SAMPLE_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             vel_valid_q, vel_valid_d;
    logic             win_end;

    assign win_end = (timer_q == TMR_W'(SAMPLE_CYCLES - 1));

    always_comb begin
        timer_d     = win_end ? '0 : timer_q + TMR_W'(1);
        vel_valid_d = win_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q     <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            vel_valid_q <= vel_valid_d;
        end
    end

    assign vel_valid = vel_valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        qei_channel #(
            .POS_W   (POS_W),
            .VEL_W   (VEL_W),
            .CNT_MODE(CNT_MODE),
            .FILT_LEN(FILT_LEN),
            .POS_MIN (POS_MIN),
            .POS_MAX (POS_MAX)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .a_in        (ch_a[i]),
            .b_in        (ch_b[i]),
            .pos_clr     (pos_clr[i]),
            .pos_load    (pos_load[i]),
            .pos_load_val(pos_load_val),
            .err_clr     (err_clr[i]),
            .win_end     (win_end),
            .position    (position[i*POS_W +: POS_W]),
            .dir         (dir[i]),
            .limit       (limit[i]),
            .err         (err[i]),
            .vel         (vel[i*VEL_W +: VEL_W])
        );
    end

endmodule

// File: tb/tb_qei_multi.sv
// tb/tb_qei_multi.sv - directed table-driven bench for qei_multi
module tb_qei_multi;

    localparam int PW = 32;
    localparam int VW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [1:0]      ch_a = '0, ch_b = '0, pos_clr = '0, pos_load = '0, err_clr = '0;
    logic [1:0]      s_a = '0, s_b = '0, s_clr = '0, s_load = '0;
    logic [PW-1:0]   load_val = '0;
    logic [2*PW-1:0] pos4, pos2, pos1, poss;
    logic [1:0]      dir4, dir2, dir1, dirs, lim4, lim2, lim1, lims, err4, err2, err1, errs;
    logic [2*VW-1:0] vel4, vel2, vel1, vels;
    logic            vv4, vv2, vv1, vvs;

    qei_multi #(.CNT_MODE(2), .FILT_LEN(3), .SAMPLE_CYCLES(100)) u_m4 (
        .clk(clk), .rst(rst), .ch_a(ch_a), .ch_b(ch_b), .pos_clr(pos_clr), .pos_load(pos_load),
        .pos_load_val(load_val), .err_clr(err_clr), .position(pos4), .dir(dir4), .limit(lim4),
        .err(err4), .vel(vel4), .vel_valid(vv4));
    qei_multi #(.CNT_MODE(1), .FILT_LEN(3), .SAMPLE_CYCLES(100)) u_m2 (
        .clk(clk), .rst(rst), .ch_a(ch_a), .ch_b(ch_b), .pos_clr(pos_clr), .pos_load(pos_load),
        .pos_load_val(load_val), .err_clr(err_clr), .position(pos2), .dir(dir2), .limit(lim2),
        .err(err2), .vel(vel2), .vel_valid(vv2));
    qei_multi #(.CNT_MODE(0), .FILT_LEN(3), .SAMPLE_CYCLES(100)) u_m1 (
        .clk(clk), .rst(rst), .ch_a(ch_a), .ch_b(ch_b), .pos_clr(pos_clr), .pos_load(pos_load),
        .pos_load_val(load_val), .err_clr(err_clr), .position(pos1), .dir(dir1), .limit(lim1),
        .err(err1), .vel(vel1), .vel_valid(vv1));
    qei_multi #(.CNT_MODE(2), .FILT_LEN(3), .SAMPLE_CYCLES(100), .POS_MAX(5)) u_sat (
        .clk(clk), .rst(rst), .ch_a(s_a), .ch_b(s_b), .pos_clr(s_clr), .pos_load(s_load),
        .pos_load_val(load_val), .err_clr(err_clr), .position(poss), .dir(dirs), .limit(lims),
        .err(errs), .vel(vels), .vel_valid(vvs));

    typedef struct {
        logic [1:0] ab;
        int         p4;
        int         p2;
        int         p1;
        logic       d;
        logic       e;
    } vec_t;

    vec_t tbl[16];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   vv_cnt = 0;
    int   vv_at = 0;

    function automatic logic signed [PW-1:0] pf(input logic [2*PW-1:0] v, input int c);
        return $signed(v[c*PW +: PW]);
    endfunction

    function automatic logic signed [VW-1:0] vf(input logic [2*VW-1:0] v, input int c);
        return $signed(v[c*VW +: VW]);
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (vv4 === 1'b1) begin
            vv_cnt++;
            vv_at = cyc;
        end
    endtask

    task automatic step_ab(input logic [1:0] ab);
        ch_a[0] = ab[1];
        ch_b[0] = ab[0];
        repeat (8) tick();
    endtask

    task automatic step_sat(input logic [1:0] ab);
        s_a[0] = ab[1];
        s_b[0] = ab[0];
        repeat (8) tick();
    endtask

    task automatic wait_pulse(output int at);
        int c0;
        c0 = vv_cnt;
        at = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (vv_cnt != c0) begin
                at = vv_at;
                break;
            end
        end
    endtask

    task automatic chk_pos(input string tag, input int p4, input int p2, input int p1);
        chk({tag, " pos x4"}, pf(pos4, 0), p4);
        chk({tag, " pos x2"}, pf(pos2, 0), p2);
        chk({tag, " pos x1"}, pf(pos1, 0), p1);
    endtask

    logic [1:0] fwd [4];
    int         t_rel, t_at, t_prev;

    initial begin
        fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
        tbl[0]  = '{2'b10, 1, 1, 1, 1'b1, 1'b0};
        tbl[1]  = '{2'b11, 2, 1, 1, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 3, 2, 1, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 4, 2, 1, 1'b1, 1'b0};
        tbl[4]  = '{2'b10, 5, 3, 2, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 6, 3, 2, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 7, 4, 2, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 8, 4, 2, 1'b1, 1'b0};
        tbl[8]  = '{2'b01, 7, 4, 2, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 6, 3, 2, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 5, 3, 2, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 4, 2, 1, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 5, 3, 2, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 4, 2, 1, 1'b0, 1'b0};
        tbl[14] = '{2'b10, 5, 3, 2, 1'b1, 1'b0};
        tbl[15] = '{2'b00, 4, 2, 1, 1'b0, 1'b0};

        repeat (3) tick();
        chk("rst pos", pf(pos4, 0), 0);
        chk("rst dir", dir4, 0);
        chk("rst limit", lim4, 0);
        chk("rst err", err4, 0);
        chk("rst vel", vf(vel4, 0), 0);
        chk("rst vel_valid", vv4, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("idle pos after rst", pf(pos4, 0), 0);

        for (int i = 0; i < 16; i++) begin
            step_ab(tbl[i].ab);
            chk_pos($sformatf("tbl%0d", i), tbl[i].p4, tbl[i].p2, tbl[i].p1);
            chk($sformatf("tbl%0d dir x4", i), dir4[0], tbl[i].d);
            chk($sformatf("tbl%0d dir x1", i), dir1[0], tbl[i].d);
            chk($sformatf("tbl%0d err", i), err4[0], tbl[i].e);
        end
        chk("ch1 untouched", pf(pos4, 1), 0);

        for (int k = 0; k < 10; k++) begin
            step_ab(2'b10);
            chk($sformatf("dither%0d hi x1", k), pf(pos1, 0), 2);
            step_ab(2'b00);
        end
        chk_pos("dither end", 4, 2, 1);

        step_ab(2'b11);
        chk_pos("illegal", 4, 2, 1);
        chk("illegal err x4", err4[0], 1);
        chk("illegal err x1", err1[0], 1);
        chk("illegal dir", dir4[0], 0);
        chk("illegal err ch1", err4[1], 0);

        ch_a[0] = 1'b0;
        ch_b[0] = 1'b0;
        repeat (4) tick();
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk("err_clr vs illegal", err4[0], 1);
        chk("err_clr vs illegal pos", pf(pos4, 0), 4);
        repeat (4) tick();
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk("err_clr alone", err4[0], 0);

        ch_a[0] = 1'b1;
        repeat (2) tick();
        ch_a[0] = 1'b0;
        repeat (10) tick();
        chk_pos("glitch", 4, 2, 1);

        ch_a[0] = 1'b1;
        repeat (4) tick();
        chk("latency early", pf(pos4, 0), 4);
        tick();
        chk_pos("latency", 5, 3, 2);
        ch_a[0] = 1'b0;
        repeat (10) tick();

        for (int k = 1; k <= 10; k++) begin
            step_sat(fwd[(k - 1) % 4]);
            chk($sformatf("sat step%0d pos", k), pf(poss, 0), (k < 5) ? k : 5);
            chk($sformatf("sat step%0d limit", k), lims[0], (k >= 5) ? 1 : 0);
        end
        load_val = 32'd3;
        s_load[0] = 1'b1;
        tick();
        s_load[0] = 1'b0;
        chk("load pos", pf(poss, 0), 3);
        chk("load limit", lims[0], 0);
        step_sat(2'b01);
        chk("post-load step", pf(poss, 0), 4);
        step_sat(2'b00);
        chk("resat limit", lims[0], 1);
        s_clr[0] = 1'b1;
        s_load[0] = 1'b1;
        tick();
        s_clr[0] = 1'b0;
        s_load[0] = 1'b0;
        chk("clr over load", pf(poss, 0), 0);
        chk("clr limit", lims[0], 0);

        ch_a = '0;
        ch_b = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        t_rel = cyc;
        for (int k = 0; k < 7; k++) begin
            step_ab(fwd[k % 4]);
        end
        wait_pulse(t_at);
        chk("win1 timing", t_at - t_rel, 100);
        chk("win1 vel x4", vf(vel4, 0), 7);
        chk("win1 vel x2", vf(vel2, 0), 4);
        chk("win1 vel x1", vf(vel1, 0), 2);
        chk("win1 vel ch1", vf(vel4, 1), 0);
        tick();
        chk("vel_valid width", vv4, 0);
        t_prev = t_at;
        step_ab(2'b11);
        step_ab(2'b10);
        step_ab(2'b00);
        wait_pulse(t_at);
        chk("win2 timing", t_at - t_prev, 100);
        chk("win2 vel x4", vf(vel4, 0), -3);
        chk("win2 vel x2", vf(vel2, 0), -2);
        chk("win2 vel x1", vf(vel1, 0), -1);

        repeat (20) tick();
        step_ab(2'b10);
        rst = 1'b1;
        ch_a = '0;
        ch_b = '0;
        tick();
        chk("midrst vel", vf(vel4, 0), 0);
        chk("midrst pos", pf(pos4, 0), 0);
        chk("midrst vel_valid", vv4, 0);
        rst = 1'b0;
        t_rel = cyc;
        wait_pulse(t_at);
        chk("midrst timing", t_at - t_rel, 100);
        chk("midrst next vel", vf(vel4, 0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
